prog_counter: RTL and testbench



---
 rtl/prog_counter.sv | 165 ++++++++++++++++
 tb/tb_prog_counter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_counter.sv
`default_nettype none
// ============================================================================
// Module   : prog_counter
// Purpose  : Programmable timer/sequencer core. Configurable width, prescaler,
//            four counting modes (up-wrap, down-wrap, bounce, one-shot),
//            terminal value, synchronous load and registered event outputs.
// Revision : 1.0 - initial release
// ============================================================================
module prog_counter #(
  parameter int WIDTH   = 16,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [WIDTH-1:0]   top,
  input  logic [PRESC_W-1:0] presc,
  output logic [WIDTH-1:0]   count,
  output logic               dir,
  output logic               tc,
  output logic               done
);

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_ONCE   = 2'b11;

  localparam logic [WIDTH-1:0]   CNT_ZERO = '0;
  localparam logic [WIDTH-1:0]   CNT_ONE  = WIDTH'(1);
  localparam logic [PRESC_W-1:0] PS_ZERO  = '0;
  localparam logic [PRESC_W-1:0] PS_ONE   = PRESC_W'(1);

  logic [PRESC_W-1:0] presc_cnt;
  logic [PRESC_W-1:0] presc_nxt;
  logic [WIDTH-1:0]   count_nxt;
  logic               dir_nxt;
  logic               tc_nxt;
  logic               done_nxt;

  logic               tick;
  logic [WIDTH-1:0]   up_val;
  logic [WIDTH-1:0]   dn_val;

  // A tick fires when enabled and the prescaler has reached its divide value.
  assign tick   = en && (presc_cnt == presc);
  assign up_val = count + CNT_ONE;
  assign dn_val = count - CNT_ONE;

  // Next-state computation: load has priority over a tick, otherwise hold.
  // tc defaults to 0 so it only pulses on edges that carry an event.
  always_comb begin
    presc_nxt = presc_cnt;
    count_nxt = count;
    dir_nxt   = dir;
    tc_nxt    = 1'b0;
    done_nxt  = done;

    if (load) begin
      presc_nxt = PS_ZERO;
      count_nxt = load_val;
      done_nxt  = 1'b0;
      dir_nxt   = (mode != MODE_DOWN);
    end else if (en) begin
      presc_nxt = tick ? PS_ZERO : (presc_cnt + PS_ONE);
      if (tick) begin
        case (mode)
          MODE_UP: begin
            dir_nxt = 1'b1;
            if (count >= top) begin
              count_nxt = CNT_ZERO;
              tc_nxt    = 1'b1;
            end else begin
              count_nxt = up_val;
            end
          end

          MODE_DOWN: begin
            dir_nxt = 1'b0;
            if (count == CNT_ZERO) begin
              count_nxt = top;
              tc_nxt    = 1'b1;
            end else begin
              count_nxt = dn_val;
            end
          end

          MODE_BOUNCE: begin
            if (top == CNT_ZERO) begin
              // Degenerate range: pinned at zero, every tick is an event.
              count_nxt = CNT_ZERO;
              tc_nxt    = 1'b1;
            end else if (dir && (count < top)) begin
              count_nxt = up_val;
              if (up_val == top) begin
                dir_nxt = 1'b0;
                tc_nxt  = 1'b1;
              end
            end else if (count != CNT_ZERO) begin
              // Covers normal down-counting and an up-count that found
              // itself at or above top (e.g. after top was lowered).
              count_nxt = dn_val;
              dir_nxt   = 1'b0;
              if (dn_val == CNT_ZERO) begin
                dir_nxt = 1'b1;
                tc_nxt  = 1'b1;
              end
            end else begin
              // Heading down but already at zero (entered from another
              // mode): turn around and start climbing.
              count_nxt = up_val;
              dir_nxt   = 1'b1;
              if (up_val == top) begin
                dir_nxt = 1'b0;
                tc_nxt  = 1'b1;
              end
            end
          end

          MODE_ONCE: begin
            dir_nxt = 1'b1;
            if (!done) begin
              if (count < top) begin
                count_nxt = up_val;
                if (up_val == top) begin
                  done_nxt = 1'b1;
                  tc_nxt   = 1'b1;
                end
              end else begin
                done_nxt = 1'b1;
                tc_nxt   = 1'b1;
              end
            end
          end

          default: begin
            count_nxt = count;
          end
        endcase
      end
    end
  end

  // State register with asynchronous clear of every output and the prescaler.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt <= PS_ZERO;
      count     <= CNT_ZERO;
      dir       <= 1'b1;
      tc        <= 1'b0;
      done      <= 1'b0;
    end else begin
      presc_cnt <= presc_nxt;
      count     <= count_nxt;
      dir       <= dir_nxt;
      tc        <= tc_nxt;
      done      <= done_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prog_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_counter
// Purpose  : Directed self-checking bench for prog_counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_counter;

  logic        clk;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] top;
  logic [7:0]  presc;
  logic [15:0] count;
  logic        dir;
  logic        tc;
  logic        done;

  int checks = 0;
  int errors = 0;

  prog_counter #(.WIDTH(16), .PRESC_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .top      (top),
    .presc    (presc),
    .count    (count),
    .dir      (dir),
    .tc       (tc),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    en   = 1'b0;
    load = 1'b0;
    rst  = 1'b1;
    #2;
    rst  = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (count !== 16'h0 || dir !== 1'b1 || tc !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_async count=%0h dir=%0b tc=%0b done=%0b exp count=0 dir=1 tc=0 done=0",
               count, dir, tc, done);
    end
    en = 1'b1;
    step();
    checks++;
    if (count !== 16'h0) begin
      errors++;
      $display("FAIL reset_hold count=%0h exp 0", count);
    end
    rst = 1'b0;
  endtask

  task automatic test_up_wrap();
    logic [15:0] exp_c;
    logic        exp_t;
    do_reset();
    mode = 2'b00; top = 16'd3; presc = 8'd0; en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      exp_c = 16'(i % 4);
      exp_t = ((i % 4) == 0);
      checks++;
      if (count !== exp_c) begin
        errors++;
        $display("FAIL up_wrap_count step=%0d count=%0d exp %0d", i, count, exp_c);
      end
      checks++;
      if (tc !== exp_t) begin
        errors++;
        $display("FAIL up_wrap_tc step=%0d tc=%0b exp %0b", i, tc, exp_t);
      end
    end
    en = 1'b0;
    step();
    checks++;
    if (count !== 16'd0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL en_low_tc_drop count=%0d tc=%0b exp count=0 tc=0", count, tc);
    end
  endtask

  task automatic test_prescaler();
    logic [15:0] exp_c;
    do_reset();
    mode = 2'b00; top = 16'd255; presc = 8'd2; en = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      exp_c = 16'(i / 3);
      checks++;
      if (count !== exp_c || tc !== 1'b0) begin
        errors++;
        $display("FAIL presc_count step=%0d count=%0d tc=%0b exp count=%0d tc=0", i, count, tc, exp_c);
      end
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (count !== 16'd2) begin
        errors++;
        $display("FAIL presc_freeze cycle=%0d count=%0d exp 2", i, count);
      end
    end
    en = 1'b1;
    step();
    checks++;
    if (count !== 16'd2) begin
      errors++;
      $display("FAIL presc_resume_a count=%0d exp 2", count);
    end
    step();
    checks++;
    if (count !== 16'd3) begin
      errors++;
      $display("FAIL presc_resume_b count=%0d exp 3", count);
    end
  endtask

  task automatic test_bounce();
    logic [15:0] exp_c [6] = '{16'd1, 16'd2, 16'd1, 16'd0, 16'd1, 16'd2};
    logic        exp_d [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        exp_t [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    mode = 2'b10; top = 16'd2; presc = 8'd0; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (count !== exp_c[i] || dir !== exp_d[i] || tc !== exp_t[i]) begin
        errors++;
        $display("FAIL bounce step=%0d count=%0d dir=%0b tc=%0b exp count=%0d dir=%0b tc=%0b",
                 i, count, dir, tc, exp_c[i], exp_d[i], exp_t[i]);
      end
    end
    top = 16'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (count !== 16'd0 || tc !== 1'b1) begin
        errors++;
        $display("FAIL bounce_top0 step=%0d count=%0d tc=%0b exp count=0 tc=1", i, count, tc);
      end
    end
  endtask

  task automatic test_one_shot();
    logic [15:0] exp_c [5] = '{16'd3, 16'd4, 16'd5, 16'd5, 16'd5};
    logic        exp_n [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        exp_t [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    mode = 2'b11; top = 16'd5; presc = 8'd0; en = 1'b1;
    load = 1'b1; load_val = 16'd3;
    for (int i = 0; i < 5; i++) begin
      step();
      load = 1'b0;
      checks++;
      if (count !== exp_c[i] || done !== exp_n[i] || tc !== exp_t[i]) begin
        errors++;
        $display("FAIL one_shot step=%0d count=%0d done=%0b tc=%0b exp count=%0d done=%0b tc=%0b",
                 i, count, done, tc, exp_c[i], exp_n[i], exp_t[i]);
      end
    end
    load = 1'b1; load_val = 16'd0;
    step();
    load = 1'b0;
    checks++;
    if (count !== 16'd0 || done !== 1'b0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL one_shot_reload count=%0d done=%0b tc=%0b exp count=0 done=0 tc=0", count, done, tc);
    end
    step();
    checks++;
    if (count !== 16'd1 || done !== 1'b0) begin
      errors++;
      $display("FAIL one_shot_restart count=%0d done=%0b exp count=1 done=0", count, done);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_c [7] = '{16'd1, 16'd0, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0};
    logic        exp_t [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    mode = 2'b01; top = 16'd4; presc = 8'd0; en = 1'b1;
    load = 1'b1; load_val = 16'd1;
    for (int i = 0; i < 7; i++) begin
      step();
      load = 1'b0;
      checks++;
      if (count !== exp_c[i] || tc !== exp_t[i] || dir !== 1'b0) begin
        errors++;
        $display("FAIL down_wrap step=%0d count=%0d tc=%0b dir=%0b exp count=%0d tc=%0b dir=0",
                 i, count, tc, dir, exp_c[i], exp_t[i]);
      end
    end
    // Count is 0 so this tick would wrap with tc; the load must win.
    load = 1'b1; load_val = 16'd7;
    step();
    load = 1'b0;
    checks++;
    if (count !== 16'd7 || tc !== 1'b0) begin
      errors++;
      $display("FAIL load_beats_tick count=%0d tc=%0b exp count=7 tc=0", count, tc);
    end
    step();
    checks++;
    if (count !== 16'd6) begin
      errors++;
      $display("FAIL after_load count=%0d exp 6", count);
    end
  endtask

  task automatic test_async_reset();
    mode = 2'b11; top = 16'h1234; presc = 8'd0; en = 1'b1;
    load = 1'b1; load_val = 16'h1233;
    step();
    load = 1'b0;
    step();
    checks++;
    if (count !== 16'h1234 || done !== 1'b1 || tc !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset count=%0h done=%0b tc=%0b exp count=1234 done=1 tc=1", count, done, tc);
    end
    rst = 1'b1;
    #2;
    checks++;
    if (count !== 16'h0 || tc !== 1'b0 || done !== 1'b0 || dir !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset count=%0h tc=%0b done=%0b dir=%0b exp count=0 tc=0 done=0 dir=1",
               count, tc, done, dir);
    end
    mode = 2'b00; top = 16'hFFFF; presc = 8'd1;
    rst = 1'b0;
    step();
    checks++;
    if (count !== 16'd0) begin
      errors++;
      $display("FAIL restart_a count=%0h exp 0", count);
    end
    step();
    checks++;
    if (count !== 16'd1) begin
      errors++;
      $display("FAIL restart_b count=%0h exp 1", count);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; load = 1'b0;
    load_val = 16'd0; top = 16'd0; presc = 8'd0;
    test_reset();
    test_up_wrap();
    test_prescaler();
    test_bounce();
    test_one_shot();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
